// File: rtl/pe_ctx_sequencer.sv
// Context sequencer: replays buffered PE instruction words as init/run phases.
// Define PE_SEQ_PERF_EN to build the run_cycles performance counter.
`timescale 1ns/1ps
module pe_ctx_sequencer #(
    parameter int INST_W   = 28,
    parameter int DEPTH    = 8,
    parameter int CNT_W    = 16,
    parameter int INIT_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [INST_W-1:0]        cfg_inst,
    input  logic [CNT_W-1:0]         cfg_run_len,
    input  logic                     flush,
    input  logic                     start,
    input  logic                     loop_en,
    input  logic                     abort,
    output logic [INST_W-1:0]        PE_inst,
    output logic                     init,
    output logic                     run,
    output logic [$clog2(DEPTH)-1:0] ctx_idx,
    output logic [$clog2(DEPTH):0]   ctx_count,
    output logic                     busy,
    output logic                     done,
    output logic [31:0]              run_cycles
);
    localparam int               IDX_W      = $clog2(DEPTH);
    localparam logic [IDX_W:0]   FULL_COUNT = (IDX_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [CNT_W-1:0]  len;
    } ctx_t;

    ctx_t              mem_q [DEPTH];
    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ctx_idx_q, ctx_idx_d;
    logic [IDX_W:0]    ctx_count_q, ctx_count_d;
    logic [CNT_W-1:0]  phase_q, phase_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              init_q, init_d;
    logic              run_q, run_d;
    logic              done_q, done_d;

    logic              wr_en;
    logic              init_last;
    logic              run_last;
    logic              more_ctx;
    logic [CNT_W-1:0]  cur_len;

    assign cfg_ready = (state_q == S_IDLE) && (ctx_count_q < FULL_COUNT);
    assign wr_en     = cfg_valid && cfg_ready && !flush;
    assign cur_len   = mem_q[ctx_idx_q].len;
    assign init_last = (phase_q == INIT_LAST);
    // A zero run length behaves as a single run cycle.
    assign run_last  = (cur_len == '0) || (phase_q == cur_len - CNT_W'(1));
    assign more_ctx  = ({1'b0, ctx_idx_q} + (IDX_W+1)'(1)) < ctx_count_q;

    // NOTE: the buffer has no reset; ctx_count alone marks which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[ctx_count_q[IDX_W-1:0]] <= {cfg_inst, cfg_run_len};
        end
    end

    // NOTE: every *_d gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        ctx_idx_d   = ctx_idx_q;
        ctx_count_d = ctx_count_q;
        phase_d     = phase_q;
        inst_d      = inst_q;

        unique case (state_q)
            S_IDLE: begin
                if (flush) begin
                    ctx_count_d = '0;
                end else if (wr_en) begin
                    ctx_count_d = ctx_count_q + (IDX_W+1)'(1);
                end
                if (start) begin
                    if (ctx_count_d != '0) begin
                        state_d   = S_LOAD;
                        ctx_idx_d = '0;
                        phase_d   = '0;
                        // Entry 0 may be the word being written this very cycle.
                        inst_d    = (ctx_count_q == '0) ? cfg_inst : mem_q[0].inst;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                if (init_last) begin
                    state_d = S_RUN;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (run_last) begin
                    phase_d = '0;
                    if (more_ctx) begin
                        state_d   = S_LOAD;
                        ctx_idx_d = ctx_idx_q + IDX_W'(1);
                        inst_d    = mem_q[ctx_idx_d].inst;
                    end else if (loop_en) begin
                        state_d   = S_LOAD;
                        ctx_idx_d = '0;
                        inst_d    = mem_q[0].inst;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            ctx_idx_d = '0;
            phase_d   = '0;
        end

        init_d = (state_d == S_LOAD);
        run_d  = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ctx_idx_q   <= '0;
            ctx_count_q <= '0;
            phase_q     <= '0;
            inst_q      <= '0;
            init_q      <= 1'b0;
            run_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctx_idx_q   <= ctx_idx_d;
            ctx_count_q <= ctx_count_d;
            phase_q     <= phase_d;
            inst_q      <= inst_d;
            init_q      <= init_d;
            run_q       <= run_d;
            done_q      <= done_d;
        end
    end

`ifdef PE_SEQ_PERF_EN
    logic [31:0] run_cycles_q, run_cycles_d;

    always_comb begin
        run_cycles_d = run_cycles_q;
        if (state_q == S_IDLE && start) begin
            run_cycles_d = '0;
        end else if (run_q && run_cycles_q != '1) begin
            run_cycles_d = run_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_cycles_q <= '0;
        end else begin
            run_cycles_q <= run_cycles_d;
        end
    end

    assign run_cycles = run_cycles_q;
`else
    assign run_cycles = '0;
`endif

    assign PE_inst   = inst_q;
    assign init      = init_q;
    assign run       = run_q;
    assign done      = done_q;
    assign ctx_idx   = ctx_idx_q;
    assign ctx_count = ctx_count_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_pe_ctx_sequencer.sv
// Self-checking bench for pe_ctx_sequencer: directed tables plus randomized
// sequences compared against an expected init/run/done trace model.
`timescale 1ns/1ps
module tb_pe_ctx_sequencer;
    localparam int INST_W   = 28;
    localparam int DEPTH    = 8;
    localparam int CNT_W    = 16;
    localparam int INIT_CYC = 2;
    localparam int IDX_W    = $clog2(DEPTH);
`ifdef PE_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [63:0] STROBE_MASK = 64'h7_8000_0000;
    localparam logic [63:0] IDX_MASK    = 64'h0_7000_0000;

    logic              clk;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [INST_W-1:0] cfg_inst;
    logic [CNT_W-1:0]  cfg_run_len;
    logic              flush;
    logic              start;
    logic              loop_en;
    logic              abort;
    logic [INST_W-1:0] PE_inst;
    logic              init;
    logic              run;
    logic [IDX_W-1:0]  ctx_idx;
    logic [IDX_W:0]    ctx_count;
    logic              busy;
    logic              done;
    logic [31:0]       run_cycles;

    pe_ctx_sequencer #(
        .INST_W  (INST_W),
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W),
        .INIT_CYC(INIT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_inst   (cfg_inst),
        .cfg_run_len(cfg_run_len),
        .flush      (flush),
        .start      (start),
        .loop_en    (loop_en),
        .abort      (abort),
        .PE_inst    (PE_inst),
        .init       (init),
        .run        (run),
        .ctx_idx    (ctx_idx),
        .ctx_count  (ctx_count),
        .busy       (busy),
        .done       (done),
        .run_cycles (run_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [INST_W-1:0] inst;
        logic [CNT_W-1:0]  len;
    } ctx_t;

    typedef struct {
        bit                init;
        bit                run;
        bit                done;
        logic [IDX_W-1:0]  idx;
        logic [INST_W-1:0] inst;
    } step_t;

    typedef struct {
        bit                valid;
        bit                flush;
        logic [INST_W-1:0] inst;
        logic [CNT_W-1:0]  len;
        bit                exp_ready;
        int                exp_count;
    } vec_t;

    ctx_t  model_q[$];
    step_t trace_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] obs();
        return {29'b0, busy, init, run, done, ctx_idx, PE_inst};
    endfunction

    function automatic logic [63:0] step_exp(input step_t s);
        return {29'b0, 1'b1, s.init, s.run, s.done, s.idx, s.inst};
    endfunction

    task automatic write_ctx(input logic [INST_W-1:0] wi, input logic [CNT_W-1:0] wl);
        cfg_valid   = 1'b1;
        cfg_inst    = wi;
        cfg_run_len = wl;
        if (model_q.size() < DEPTH) model_q.push_back('{inst: wi, len: wl});
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        model_q.delete();
        tick();
        flush = 1'b0;
    endtask

    // Expected per-cycle strobes: INIT_CYC init cycles then max(len,1) run cycles per context.
    task automatic build_trace(input bit lp, input int abort_at);
        step_t s;
        int    n;
        trace_q.delete();
        if (model_q.size() == 0) begin
            s = '{init: 1'b0, run: 1'b0, done: 1'b1, idx: '0, inst: '0};
            trace_q.push_back(s);
        end else begin
            do begin
                for (int c = 0; c < model_q.size(); c++) begin
                    for (int i = 0; i < INIT_CYC; i++) begin
                        s = '{init: 1'b1, run: 1'b0, done: 1'b0, idx: IDX_W'(c), inst: model_q[c].inst};
                        trace_q.push_back(s);
                    end
                    n = (model_q[c].len == '0) ? 1 : int'(model_q[c].len);
                    for (int i = 0; i < n; i++) begin
                        s = '{init: 1'b0, run: 1'b1, done: 1'b0, idx: IDX_W'(c), inst: model_q[c].inst};
                        trace_q.push_back(s);
                    end
                end
            end while (lp && trace_q.size() <= abort_at);
            if (!lp) begin
                s = '{init: 1'b0, run: 1'b0, done: 1'b1, idx: '0, inst: '0};
                trace_q.push_back(s);
            end
        end
    endtask

    task automatic run_seq(input bit lp, input int abort_at, input bit ws,
                           input logic [INST_W-1:0] wi, input logic [CNT_W-1:0] wl,
                           input bit noise);
        int          rc;
        bit          aborted;
        logic [63:0] m;
        logic [31:0] exp_rc;
        start   = 1'b1;
        loop_en = lp;
        if (ws) begin
            cfg_valid   = 1'b1;
            cfg_inst    = wi;
            cfg_run_len = wl;
            if (model_q.size() < DEPTH) model_q.push_back('{inst: wi, len: wl});
        end
        build_trace(lp, abort_at);
        tick();
        start     = 1'b0;
        cfg_valid = 1'b0;
        rc        = 0;
        aborted   = 1'b0;
        for (int j = 0; j < trace_q.size(); j++) begin
            m = trace_q[j].done ? STROBE_MASK : '1;
            check("seq_step", obs() & m, step_exp(trace_q[j]) & m);
            if (trace_q[j].run) rc++;
            if (j == abort_at) abort = 1'b1;
            if (noise) begin
                start     = 1'($urandom);
                flush     = 1'($urandom);
                cfg_valid = 1'($urandom);
            end
            tick();
            abort     = 1'b0;
            start     = 1'b0;
            flush     = 1'b0;
            cfg_valid = 1'b0;
            if (j == abort_at) begin
                aborted = 1'b1;
                break;
            end
        end
        m = aborted ? (STROBE_MASK | IDX_MASK) : STROBE_MASK;
        check("seq_idle", obs() & m, 64'd0);
        check("seq_count", 64'(ctx_count), 64'(model_q.size()));
        exp_rc = PERF ? 32'(rc) : 32'd0;
        check("run_cycles", 64'(run_cycles), 64'(exp_rc));
        loop_en = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[11];
        int   n;
        bit   lp;
        int   ab;

        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{valid: 1'b1, flush: 1'b0, inst: INST_W'(32'h100 + i),
                       len: CNT_W'(i % 3), exp_ready: 1'b1, exp_count: i + 1};
        end
        tbl[8]  = '{valid: 1'b1, flush: 1'b0, inst: 28'hDEAD, len: 16'd1, exp_ready: 1'b0, exp_count: 8};
        tbl[9]  = '{valid: 1'b0, flush: 1'b1, inst: '0,       len: '0,    exp_ready: 1'b0, exp_count: 0};
        tbl[10] = '{valid: 1'b1, flush: 1'b1, inst: 28'hBEEF, len: 16'd2, exp_ready: 1'b1, exp_count: 0};

        rst = 1'b0; cfg_valid = 1'b0; cfg_inst = '0; cfg_run_len = '0;
        flush = 1'b0; start = 1'b0; loop_en = 1'b0; abort = 1'b0;
        tick();
        tick();
        check("reset_strobes", 64'({init, run, busy, done, ctx_idx, ctx_count}), 64'd0);
        check("reset_inst", 64'(PE_inst), 64'd0);
        check("reset_perf", 64'(run_cycles), 64'd0);
        rst = 1'b1;
        #1;
        check("reset_ready", 64'(cfg_ready), 64'd1);
        tick();

        // Single context of length 1.
        write_ctx(28'h965b70, 16'd1);
        run_seq(1'b0, -1, 1'b0, '0, '0, 1'b0);

        // Three contexts with lengths 3, 0, 2.
        do_flush();
        write_ctx(28'h1, 16'd3);
        write_ctx(28'h2, 16'd0);
        write_ctx(28'h3, 16'd2);
        run_seq(1'b0, -1, 1'b0, '0, '0, 1'b0);

        // Buffer fill, overflow drop, flush, flush-beats-write, then empty start.
        do_flush();
        for (int i = 0; i < 11; i++) begin
            cfg_valid   = tbl[i].valid;
            flush       = tbl[i].flush;
            cfg_inst    = tbl[i].inst;
            cfg_run_len = tbl[i].len;
            check("tbl_ready", 64'(cfg_ready), 64'(tbl[i].exp_ready));
            if (tbl[i].flush) model_q.delete();
            else if (tbl[i].valid && model_q.size() < DEPTH)
                model_q.push_back('{inst: tbl[i].inst, len: tbl[i].len});
            tick();
            cfg_valid = 1'b0;
            flush     = 1'b0;
            check("tbl_count", 64'(ctx_count), 64'(tbl[i].exp_count));
        end
        run_seq(1'b0, -1, 1'b0, '0, '0, 1'b0);

        // Two contexts looping, aborted in the second pass RUN phase.
        do_flush();
        write_ctx(28'hA, 16'd1);
        write_ctx(28'hB, 16'd2);
        run_seq(1'b1, 9, 1'b0, '0, '0, 1'b0);

        // Write and start in the same cycle, from empty and from one entry.
        do_flush();
        run_seq(1'b0, -1, 1'b1, 28'h5a5a5a5, 16'd2, 1'b0);
        run_seq(1'b0, -1, 1'b1, 28'h0123456, 16'd0, 1'b1);

        // Asynchronous reset during LOAD.
        do_flush();
        write_ctx(28'hABCDEF1, 16'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("midload_init", 64'(init), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_async", 64'({init, busy, PE_inst}), 64'd0);
        #2 rst = 1'b1;
        model_q.delete();
        tick();
        check("rst_count", 64'(ctx_count), 64'd0);
        check("rst_ready", 64'(cfg_ready), 64'd1);

        // Randomized sequences with ignored-while-busy noise.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) do_flush();
            n = int'($urandom_range(0, 3));
            for (int k = 0; k < n; k++) write_ctx(INST_W'($urandom), CNT_W'($urandom_range(0, 3)));
            lp = (model_q.size() > 0) && ($urandom_range(0, 2) == 0);
            if (lp) ab = int'($urandom_range(0, 30));
            else if ($urandom_range(0, 2) == 0) ab = int'($urandom_range(0, 20));
            else ab = -1;
            run_seq(lp, ab, ($urandom_range(0, 3) == 0), INST_W'($urandom),
                    CNT_W'($urandom_range(0, 2)), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
